// File: rtl/program_loader.sv
// program_loader: assembles the file-reader byte stream into instruction words,
// writes them to instruction memory, verifies the trailing XOR checksum and gates core reset.
module program_loader #(
  parameter int WORD_BYTES = 2,
  parameter int ADDR_WIDTH = 5,
  parameter int BASE_ADDR  = 0
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    restart,
  input  logic [7:0]              in_data,
  input  logic                    in_valid,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [8*WORD_BYTES-1:0] mem_wdata,
  output logic [ADDR_WIDTH:0]     words_loaded,
  output logic                    cpu_hold,
  output logic                    load_done,
  output logic                    load_error
);

  localparam int                    WORD_W   = 8 * WORD_BYTES;
  localparam int                    IDX_W    = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam logic [ADDR_WIDTH-1:0] BASE     = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(WORD_BYTES - 1);

  typedef enum logic [2:0] {
    WAIT_COUNT = 3'd0,
    LOAD       = 3'd1,
    CHECK      = 3'd2,
    DONE       = 3'd3,
    ERROR      = 3'd4
  } state_t;

  state_t            state;
  logic [7:0]        count;
  logic [7:0]        xor_acc;
  logic [IDX_W-1:0]  byte_idx;
  logic [WORD_W-1:0] word_acc;

  logic [WORD_W-1:0] next_word;
  logic              last_word;
  logic              oversize;

  // Bytes arrive MSB first, so each new byte shifts in at the bottom.
  assign next_word = (word_acc << 8) | WORD_W'(in_data);
  assign last_word = (32'(words_loaded) + 32'd1) == 32'(count);
  assign oversize  = 32'(in_data) > (32'd1 << ADDR_WIDTH);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= WAIT_COUNT;
      count        <= 8'd0;
      xor_acc      <= 8'd0;
      byte_idx     <= '0;
      word_acc     <= '0;
      mem_we       <= 1'b0;
      mem_addr     <= BASE;
      mem_wdata    <= '0;
      words_loaded <= '0;
      cpu_hold     <= 1'b1;
      load_done    <= 1'b0;
      load_error   <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      if (restart) begin
        // A write strobe issued last cycle is already on the bus; only the
        // in-flight byte this cycle is discarded.
        state        <= WAIT_COUNT;
        xor_acc      <= 8'd0;
        byte_idx     <= '0;
        word_acc     <= '0;
        words_loaded <= '0;
        cpu_hold     <= 1'b1;
        load_done    <= 1'b0;
        load_error   <= 1'b0;
      end else if (in_valid) begin
        case (state)
          WAIT_COUNT: begin
            count   <= in_data;
            xor_acc <= in_data;
            if (oversize) begin
              state      <= ERROR;
              load_error <= 1'b1;
            end else if (in_data == 8'd0) begin
              state <= CHECK;
            end else begin
              state <= LOAD;
            end
          end
          LOAD: begin
            xor_acc  <= xor_acc ^ in_data;
            word_acc <= next_word;
            if (byte_idx == LAST_IDX) begin
              byte_idx     <= '0;
              mem_we       <= 1'b1;
              mem_wdata    <= next_word;
              mem_addr     <= BASE + words_loaded[ADDR_WIDTH-1:0];
              words_loaded <= words_loaded + 1'b1;
              if (last_word) state <= CHECK;
            end else begin
              byte_idx <= byte_idx + 1'b1;
            end
          end
          CHECK: begin
            if (in_data == xor_acc) begin
              state     <= DONE;
              load_done <= 1'b1;
              cpu_hold  <= 1'b0;
            end else begin
              state      <= ERROR;
              load_error <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Consumes the 8-bit byte stream produced by the file reader stage (data_valid/data_out, no backpressure) and assembles it into instruction words.
- Writes the words into processor instruction memory, checks a trailing XOR checksum, and holds the processor core in reset until a valid image is loaded.
- Sits between the file reader and the instruction memory / core reset logic.

Parameters:
- WORD_BYTES, 2, bytes per instruction word; word width = 8*WORD_BYTES; legal range 1..4.
- ADDR_WIDTH, 5, instruction-memory address width; capacity = 2**ADDR_WIDTH words.
- BASE_ADDR, 0, address of the first word written.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high.
- restart  in  1  synchronous; returns the FSM to WAIT_COUNT from any state.
- in_data  in  8  byte from the upstream file reader.
- in_valid  in  1  in_data is valid this cycle; every valid cycle is consumed.
- mem_we  out  1  instruction-memory write strobe, one cycle per word.
- mem_addr  out  ADDR_WIDTH  write address.
- mem_wdata  out  8*WORD_BYTES  write data.
- words_loaded  out  ADDR_WIDTH+1  count of words written so far.
- cpu_hold  out  1  high unless the FSM is in DONE; drives the core reset.
- load_done  out  1  image loaded and checksum correct.
- load_error  out  1  size or checksum error; sticky until reset or restart.

Behaviour:
- Reset is asynchronous, active-high; clock is clock.
- Reset values:
  - mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, words_loaded=0.
  - cpu_hold=1, load_done=0, load_error=0.
  - FSM=WAIT_COUNT; byte index and running XOR cleared.
- Image format:
  - byte0 = word count N (0..255).
  - Then N*WORD_BYTES payload bytes, MSB first within each word.
  - Then one checksum byte equal to the XOR of byte0 and all payload bytes.
- Cycles with in_valid=0 are ignored and state is held. Gaps between bytes are allowed anywhere.
- FSM states:
  - WAIT_COUNT: on a valid byte, latch N and set xor=byte.
    - If N > 2**ADDR_WIDTH, go to ERROR.
    - Else if N==0, go to CHECK.
    - Else go to LOAD.
  - LOAD: each valid byte is shifted into the word assembly register (MSB first), xor^=byte, and the byte index increments.
    - On the WORD_BYTES-th byte of a word, the registered outputs update the next cycle: mem_we=1 for exactly one cycle, mem_wdata = assembled word, mem_addr = BASE_ADDR + words_loaded (mod 2**ADDR_WIDTH).
    - words_loaded increments in that same cycle and the byte index clears.
    - After the word that makes words_loaded reach N, go to CHECK.
  - CHECK: on the next valid byte, go to DONE if byte==xor, else go to ERROR.
  - DONE: load_done=1 and cpu_hold=0, both registered and asserted the cycle after the checksum byte is sampled. Further valid bytes are ignored; no writes occur.
  - ERROR: load_error=1 and cpu_hold stays 1. Further bytes are ignored.
- Write latency: 1 cycle from sampling the last byte of a word to mem_we high.
- Back-to-back valid bytes every cycle must be sustained with no loss; mem_we is never high for two consecutive cycles when WORD_BYTES>=2.
- restart:
  - Clears words_loaded, load_done, load_error, xor and byte index, sets cpu_hold=1 and returns to WAIT_COUNT.
  - A byte presented in the same cycle as restart is dropped.
  - A pending mem_we registered in the previous cycle still completes.
- Reset mid-load aborts immediately. Memory contents are left as written; words_loaded returns to 0.
- An upstream stream that ends early (in_valid never returns) leaves the FSM waiting with cpu_hold=1; there is no timeout.

Test Plan:
- Clean load, WORD_BYTES=2, bytes 02,12,34,AB,CD,checksum 02^12^34^AB^CD=42 back-to-back -> mem_we at addr0 data 1234, then addr1 data ABCD; words_loaded=2; load_done=1 and cpu_hold=0 one cycle after byte 42.
- Same stream with gaps of 0-3 idle cycles between bytes -> identical writes and data; completion delayed only by the gaps.
- Bad checksum (last byte 43 instead of 42) -> both writes occur; load_error=1, load_done=0, cpu_hold stays 1; subsequent bytes cause no mem_we.
- Oversize count N=33 with ADDR_WIDTH=5 -> ERROR after byte0; zero writes; load_error=1.
- Empty image, bytes 00,00 -> no writes; load_done=1 after the second byte; a wrong checksum 01 instead gives load_error=1.
- Reset asserted after the first word is written, then restart of a full stream -> outputs return to reset values asynchronously; the reload rewrites from BASE_ADDR; trailing bytes after DONE are ignored.
